multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control sequencer that drives the 32-bit ALU's `ALUControl` select and consumes its `Zero_Flag`. It decodes the MIPS subset lw, sw, R-type (add/sub/and/or/slt), beq, j and (optionally) addi. It steps each instruction through a fetch/decode/execute state machine and emits all datapath mux selects and write enables. Memory accesses use a `MemReady` wait handshake.

## Interface
- `RESET_STATE`, 4'd0: encoding of FETCH, the state entered on reset.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Opcode`  in  6  instruction bits [31:26], valid from DECODE onward (IR is held).
- `Funct`  in  6  instruction bits [5:0].
- `Zero_Flag`  in  1  from ALU; 1 when `Result` == 0.
- `MemReady`  in  1  memory completes the current access this cycle.
- `ALUControl`  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `IorD`, `RegDst`, `MemtoReg`  out  1 each  datapath mux selects.
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IRWrite`, `MemWrite`, `RegWrite`, `PCWrite`, `Branch`, `PCEn`  out  1 each  enables; `PCEn` = `PCWrite` | (`Branch` & `Zero_Flag`).
- `Illegal`  out  1  one-cycle pulse for an unsupported opcode/funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. Encoding is binary in a 4-bit register.
- Outputs are Moore (decoded from state). Exceptions: `IRWrite`, `PCWrite` and `MemWrite` are qualified by `MemReady` in FETCH/MEMWR, and `PCEn` depends on `Zero_Flag`.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00. IRWrite=PCWrite=MemReady. Stay until MemReady=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target precompute). Next state by Opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - anything else → FETCH with Illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
- MEMWR: IorD=1, MemWrite=MemReady. Hold until MemReady=1, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - other funct → Illegal=1, next FETCH, no ALUWB
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next is FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
- Unlisted outputs are 0 in every state. ALUControl defaults to 010.

## Timing
- Reset sampled high at an edge forces state to FETCH on that edge; it aborts any instruction mid-flight. While Reset is high, all write enables (IRWrite, PCWrite, MemWrite, RegWrite, Branch, PCEn) and Illegal are forced 0. FETCH selects are driven.
- Latency with MemReady=1 always:
  - beq, j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
  - Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- `PCEn` in BRANCH is combinational on the same-cycle `Zero_Flag`; the PC updates at the end of BRANCH.
- Illegal pulses in the last cycle of DECODE or EXEC; the next cycle is FETCH.

## Configuration
- `MULTICYCLE_ADDI_EN`:
  - Defined: ADDIEX/ADDIWB are compiled in; opcode 001000 executes in 4 cycles.
  - Undefined: those states are absent and opcode 001000 is treated as illegal (DECODE → FETCH, Illegal=1, RegWrite never asserted).

## Test plan
- Reset held 2 cycles, released with Opcode=000000, Funct=100010, MemReady=1 → FETCH, DECODE, EXEC (ALUControl=110), ALUWB (RegWrite=1, RegDst=1), FETCH.
- lw with MemReady low for 2 cycles in MEMRD → IorD=1 for 3 cycles, then MEMWB with MemtoReg=1, RegWrite=1; 7 cycles total.
- beq with Zero_Flag=1 → PCEn=1 in BRANCH. Repeat with Zero_Flag=0 → PCEn=0. Both return to FETCH.
- Opcode=111111 → Illegal=1 in DECODE, no write enables, FETCH next. Funct=000000 R-type → Illegal in EXEC.
- Reset asserted in MEMWR with MemReady=1 → MemWrite=0 that cycle; state is FETCH next.
- addi with/without `MULTICYCLE_ADDI_EN` → RegWrite in cycle 4 versus Illegal in cycle 2.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM (optional addi via MULTICYCLE_ADDI_EN)
module multicycle_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero_Flag,
    input  logic       MemReady,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       Illegal
);

    localparam logic [3:0] RESET_STATE = 4'd0;

    localparam logic [3:0] FETCH  = RESET_STATE;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [3:0] ADDIEX = 4'd9;
    localparam logic [3:0] ADDIWB = 4'd10;
`endif
    localparam logic [3:0] JUMP   = 4'd11;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [2:0] funct_alu;
    logic       funct_ok;

    // R-type function decode shared by next-state and output logic
    always_comb begin
        funct_alu = 3'b010;
        funct_ok  = 1'b1;
        case (Funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (MemReady) state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (MemReady) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (MemReady) state_d = FETCH;
            EXEC:   state_d = funct_ok ? ALUWB : FETCH;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs, with memory handshakes qualifying the write enables
    always_comb begin
        ALUControl = 3'b010;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        PCSrc      = 2'b00;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        Illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_J: Illegal = 1'b0;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI: Illegal = 1'b0;
`endif
                    default: Illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:  IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = MemReady;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                Illegal    = !funct_ok;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: RegWrite = 1'b1;
`endif
            default: ;
        endcase
        if (Reset) begin
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            Illegal  = 1'b0;
        end
        PCEn = PCWrite | (Branch & Zero_Flag);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - phase-list reference model bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero_Flag;
    logic       MemReady;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD, RegDst, MemtoReg;
    logic [1:0] PCSrc;
    logic       IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn, Illegal;

    int total = 0;
    int bad   = 0;
    byte phase_q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .Clk(clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
        .Zero_Flag(Zero_Flag), .MemReady(MemReady),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCEn(PCEn), .Illegal(Illegal)
    );

    logic [17:0] obs;
    assign obs = {ALUControl, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSrc,
                  IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn, Illegal};

    function automatic bit op_supported(input logic [5:0] op);
        case (op)
            6'h23, 6'h2b, 6'h00, 6'h04, 6'h02: return 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            6'h08: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit funct_valid(input logic [5:0] fn);
        return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2a);
    endfunction

    // Instruction -> sequence of phases, one letter per FSM step
    function automatic void build_phases(input logic [5:0] op, input logic [5:0] fn);
        phase_q = {};
        phase_q.push_back("F");
        phase_q.push_back("D");
        case (op)
            6'h23: begin phase_q.push_back("A"); phase_q.push_back("R"); phase_q.push_back("W"); end
            6'h2b: begin phase_q.push_back("A"); phase_q.push_back("S"); end
            6'h00: begin phase_q.push_back("E"); if (funct_valid(fn)) phase_q.push_back("X"); end
            6'h04: phase_q.push_back("B");
            6'h02: phase_q.push_back("J");
`ifdef MULTICYCLE_ADDI_EN
            6'h08: begin phase_q.push_back("I"); phase_q.push_back("Y"); end
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input byte ph, input logic mr, input logic zero,
                                            input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] alu = 3'b010;
        logic a = 1'b0, iord = 1'b0, rdst = 1'b0, m2r = 1'b0;
        logic [1:0] b = 2'b00, pcs = 2'b00;
        logic irw = 1'b0, mw = 1'b0, rw = 1'b0, pcw = 1'b0, br = 1'b0, il = 1'b0;
        case (ph)
            "F": begin b = 2'b01; irw = mr; pcw = mr; end
            "D": begin b = 2'b11; il = !op_supported(op); end
            "A": begin a = 1'b1; b = 2'b10; end
            "R": iord = 1'b1;
            "W": begin m2r = 1'b1; rw = 1'b1; end
            "S": begin iord = 1'b1; mw = mr; end
            "E": begin
                a = 1'b1;
                case (fn)
                    6'h20: alu = 3'b010;
                    6'h22: alu = 3'b110;
                    6'h24: alu = 3'b000;
                    6'h25: alu = 3'b001;
                    6'h2a: alu = 3'b111;
                    default: il = 1'b1;
                endcase
            end
            "X": begin rdst = 1'b1; rw = 1'b1; end
            "B": begin a = 1'b1; alu = 3'b110; pcs = 2'b01; br = 1'b1; end
            "J": begin pcs = 2'b10; pcw = 1'b1; end
            "I": begin a = 1'b1; b = 2'b10; end
            "Y": rw = 1'b1;
            default: ;
        endcase
        return {alu, a, b, iord, rdst, m2r, pcs, irw, mw, rw, pcw, br, pcw | (br & zero), il};
    endfunction

    function automatic logic [17:0] reset_mask(input logic [17:0] v);
        return v & ~18'h0007F;
    endfunction

    task automatic check(input logic [17:0] e, input string tag);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Call at a negedge; returns at a later negedge
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int rd_stalls, input bit abort_sw, input bit rand_mr,
                             input string name);
        int stalls = rd_stalls;
        build_phases(op, fn);
        Opcode = op;
        Funct = fn;
        Zero_Flag = zero;
        foreach (phase_q[p]) begin
            byte ph = phase_q[p];
            if (ph == "F" || ph == "R" || ph == "S") begin
                logic mr;
                int guard = 0;
                do begin
                    if (ph == "R" && stalls > 0) begin
                        mr = 1'b0;
                        stalls--;
                    end else if (rand_mr && guard < 20) begin
                        mr = ($urandom_range(0, 3) != 0);
                    end else begin
                        mr = 1'b1;
                    end
                    guard++;
                    if (abort_sw && ph == "S") begin
                        Reset = 1'b1;
                        MemReady = 1'b1;
                        #1 check(reset_mask(exp_vec("S", 1'b1, zero, op, fn)), $sformatf("%s abort", name));
                        @(negedge clk);
                        Reset = 1'b0;
                        return;
                    end
                    MemReady = mr;
                    #1 check(exp_vec(ph, mr, zero, op, fn), $sformatf("%s ph=%c", name, ph));
                    @(negedge clk);
                end while (!mr);
            end else begin
                MemReady = 1'($urandom_range(0, 1));
                #1 check(exp_vec(ph, MemReady, zero, op, fn), $sformatf("%s ph=%c", name, ph));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Opcode = 6'h00;
        Funct = 6'h22;
        Zero_Flag = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check(reset_mask(exp_vec("F", 1'b1, 1'b0, 6'h00, 6'h22)), "reset");
        @(negedge clk);
        Reset = 1'b0;

        run_instr(6'h00, 6'h22, 1'b0, 0, 1'b0, 1'b0, "sub");
        run_instr(6'h23, 6'h00, 1'b0, 2, 1'b0, 1'b0, "lw_stall");
        run_instr(6'h04, 6'h00, 1'b1, 0, 1'b0, 1'b0, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, 0, 1'b0, 1'b0, "beq_not");
        run_instr(6'h3f, 6'h00, 1'b0, 0, 1'b0, 1'b0, "bad_op");
        run_instr(6'h00, 6'h00, 1'b0, 0, 1'b0, 1'b0, "bad_funct");
        run_instr(6'h2b, 6'h00, 1'b0, 0, 1'b1, 1'b0, "sw_abort");
        run_instr(6'h08, 6'h00, 1'b0, 0, 1'b0, 1'b0, "addi");
        run_instr(6'h02, 6'h00, 1'b0, 0, 1'b0, 1'b0, "jump");

        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            case ($urandom_range(0, 6))
                0: op = 6'h23;
                1: op = 6'h2b;
                2: op = 6'h00;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: op = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2a;
                default: fn = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 1'b1, "rand");
        end

        MemReady = 1'b0;
        #1 check(exp_vec("F", 1'b0, Zero_Flag, Opcode, Funct), "final_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
